// File: rtl/row_frame_assembler.sv
// Byte-stream to LED row assembler: header + BYTES_PER_ROW data bytes
// become one row write with panel/row address for the cube controller.
module row_frame_assembler #(
   parameter int BYTES_PER_ROW = 48,
   parameter int ERR_CNT_W     = 8,
   parameter int FRAME_CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 in_data,
   input  logic                       in_valid,
   input  logic                       in_sof,
   output logic                       in_ready,
   output logic [8*BYTES_PER_ROW-1:0] row_data,
   output logic [3:0]                 row_data_row_addr,
   output logic [1:0]                 row_data_panel_addr,
   output logic                       row_data_write_enable,
   output logic [FRAME_CNT_W-1:0]     frames_written,
   output logic [ERR_CNT_W-1:0]       error_count,
   output logic                       error_pulse
);

   localparam int W  = 8 * BYTES_PER_ROW;
   localparam int CW = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WRITE,
      DISCARD
   } state_t;

   state_t                 state_q, state_d;
   logic [5:0]             hdr_q, hdr_d;
   logic [W-1:0]           shift_q, shift_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [W-1:0]           row_q, row_d;
   logic [3:0]             raddr_q, raddr_d;
   logic [1:0]             paddr_q, paddr_d;
   logic [FRAME_CNT_W-1:0] frames_q, frames_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic                   err_q, err_d;
   logic                   acc;
   logic                   take_hdr;

   assign in_ready = (state_q != WRITE);
   assign acc      = in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      hdr_d     = hdr_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      row_d     = row_q;
      raddr_d   = raddr_q;
      paddr_d   = paddr_q;
      frames_d  = frames_q;
      err_cnt_d = err_cnt_q;
      err_d     = 1'b0;
      take_hdr  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (acc) begin
               if (in_sof) take_hdr = 1'b1;
               else        err_d    = 1'b1;
            end
         end
         LOAD: begin
            if (acc && in_sof) begin
               err_d    = 1'b1;
               take_hdr = 1'b1;
            end else if (acc) begin
               shift_d = {shift_q[W-9:0], in_data};
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == CW'(BYTES_PER_ROW - 1)) begin
                  // Outputs load on entry so they are valid alongside the strobe.
                  state_d  = WRITE;
                  row_d    = {shift_q[W-9:0], in_data};
                  raddr_d  = hdr_q[3:0];
                  paddr_d  = hdr_q[5:4];
                  frames_d = frames_q + FRAME_CNT_W'(1);
               end
            end
         end
         WRITE: begin
            state_d = IDLE;
         end
         DISCARD: begin
            if (acc && in_sof) take_hdr = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (take_hdr) begin
         hdr_d = in_data[5:0];
         cnt_d = '0;
         if (in_data[7:6] == 2'b00) begin
            state_d = LOAD;
         end else begin
            state_d = DISCARD;
            err_d   = 1'b1;
         end
      end

      if (err_d && (err_cnt_q != '1))
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         hdr_q     <= '0;
         shift_q   <= '0;
         cnt_q     <= '0;
         row_q     <= '0;
         raddr_q   <= '0;
         paddr_q   <= '0;
         frames_q  <= '0;
         err_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         hdr_q     <= hdr_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         row_q     <= row_d;
         raddr_q   <= raddr_d;
         paddr_q   <= paddr_d;
         frames_q  <= frames_d;
         err_cnt_q <= err_cnt_d;
         err_q     <= err_d;
      end
   end

   assign row_data              = row_q;
   assign row_data_row_addr     = raddr_q;
   assign row_data_panel_addr   = paddr_q;
   assign row_data_write_enable = (state_q == WRITE);
   assign frames_written        = frames_q;
   assign error_count           = err_cnt_q;
   assign error_pulse           = err_q;

endmodule

// File: tb/tb_row_frame_assembler.sv
// Directed bench for row_frame_assembler: framing, latency, errors,
// mid-frame reset and error counter saturation.
module tb_row_frame_assembler;

   localparam int N = 48;
   localparam int W = 8 * N;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_sof = 1'b0;
   logic          in_ready;
   logic [W-1:0]  row_data;
   logic [3:0]    row_addr;
   logic [1:0]    panel_addr;
   logic          we;
   logic [15:0]   frames_written;
   logic [7:0]    error_count;
   logic          error_pulse;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int we_cnt = 0;
   int ep_cnt = 0;
   int nr_cnt = 0;
   int we_cyc = -1;
   int hdr_cyc = -1;
   logic [W-1:0] exp_row;

   row_frame_assembler #(
      .BYTES_PER_ROW(N),
      .ERR_CNT_W(8),
      .FRAME_CNT_W(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_sof(in_sof),
      .in_ready(in_ready),
      .row_data(row_data),
      .row_data_row_addr(row_addr),
      .row_data_panel_addr(panel_addr),
      .row_data_write_enable(we),
      .frames_written(frames_written),
      .error_count(error_count),
      .error_pulse(error_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!reset) begin
         if (we) begin
            we_cnt++;
            we_cyc = cyc;
         end
         if (error_pulse) ep_cnt++;
         if (!in_ready) nr_cnt++;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs,
                        input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      we_cnt = 0;
      ep_cnt = 0;
      nr_cnt = 0;
      we_cyc = -1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      clr();
   endtask

   task automatic send(input logic [7:0] d, input logic s);
      int g = 0;
      in_data  = d;
      in_sof   = s;
      in_valid = 1'b1;
      while (!in_ready && g < 4) begin
         step();
         g++;
      end
      n_cmp++;
      if (g >= 4) begin
         n_fail++;
         $error("FAIL ready_timeout: observed 0 expected 1");
      end
      step();
      if (s) hdr_cyc = cyc;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      clr();
      idle(1);

      check("rst_ready", W'(in_ready), W'(1));
      check("rst_row", row_data, '0);
      check("rst_raddr", W'(row_addr), '0);
      check("rst_paddr", W'(panel_addr), '0);
      check("rst_we", W'(we), '0);
      check("rst_frames", W'(frames_written), '0);
      check("rst_errcnt", W'(error_count), '0);
      check("rst_epulse", W'(error_pulse), '0);

      // Frame 1: header 0x25, bytes 0x00..0x2F back-to-back
      exp_row = '0;
      for (int k = 0; k < N; k++) exp_row[8*(N-k)-1 -: 8] = 8'(k);
      send(8'h25, 1'b1);
      for (int k = 0; k < N; k++) send(8'(k), 1'b0);
      idle(3);
      check("f1_we_cnt", W'(we_cnt), W'(1));
      check("f1_latency", W'(we_cyc - hdr_cyc), W'(48));
      check("f1_top_byte", W'(row_data[383:376]), W'(8'h00));
      check("f1_low_byte", W'(row_data[7:0]), W'(8'h2F));
      check("f1_row", row_data, exp_row);
      check("f1_raddr", W'(row_addr), W'(5));
      check("f1_paddr", W'(panel_addr), W'(2));
      check("f1_frames", W'(frames_written), W'(1));
      check("f1_notready", W'(nr_cnt), W'(1));
      check("f1_errcnt", W'(error_count), '0);

      // Same frame with random valid gaps
      clr();
      send(8'h25, 1'b1);
      for (int k = 0; k < N; k++) begin
         idle($urandom_range(0, 3));
         send(8'(k), 1'b0);
      end
      idle(3);
      check("f2_we_cnt", W'(we_cnt), W'(1));
      check("f2_row", row_data, exp_row);
      check("f2_raddr", W'(row_addr), W'(5));
      check("f2_paddr", W'(panel_addr), W'(2));
      check("f2_frames", W'(frames_written), W'(2));
      check("f2_epulses", W'(ep_cnt), '0);
      check("f2_errcnt", W'(error_count), '0);

      // Header 0x13 abandoned after 20 bytes by header 0x3F
      do_reset();
      send(8'h13, 1'b1);
      for (int k = 0; k < 20; k++) send(8'h55, 1'b0);
      idle(2);
      check("f3_row_hold", row_data, '0);
      send(8'h3F, 1'b1);
      for (int k = 0; k < N; k++) send(8'hAA, 1'b0);
      idle(3);
      check("f3_epulses", W'(ep_cnt), W'(1));
      check("f3_errcnt", W'(error_count), W'(1));
      check("f3_we_cnt", W'(we_cnt), W'(1));
      check("f3_paddr", W'(panel_addr), W'(3));
      check("f3_raddr", W'(row_addr), W'(15));
      check("f3_row", row_data, {N{8'hAA}});
      check("f3_frames", W'(frames_written), W'(1));

      // Bad header 0x80 frame discarded, then header 0x01 frame
      do_reset();
      send(8'h80, 1'b1);
      for (int k = 0; k < N; k++) send(8'h99, 1'b0);
      idle(2);
      check("f4_bad_we", W'(we_cnt), '0);
      send(8'h01, 1'b1);
      for (int k = 0; k < N; k++) send(8'h11, 1'b0);
      idle(3);
      check("f4_errcnt", W'(error_count), W'(1));
      check("f4_epulses", W'(ep_cnt), W'(1));
      check("f4_we_cnt", W'(we_cnt), W'(1));
      check("f4_raddr", W'(row_addr), W'(1));
      check("f4_paddr", W'(panel_addr), W'(0));
      check("f4_row", row_data, {N{8'h11}});

      // Reset after 30 data bytes, then a fresh header 0x00 frame
      clr();
      send(8'h00, 1'b1);
      for (int k = 0; k < 30; k++) send(8'h77, 1'b0);
      do_reset();
      idle(1);
      check("f5_row_zero", row_data, '0);
      check("f5_frames_zero", W'(frames_written), '0);
      check("f5_errcnt_zero", W'(error_count), '0);
      exp_row = '0;
      for (int k = 0; k < N; k++) exp_row[8*(N-k)-1 -: 8] = 8'(k + 8'h40);
      send(8'h00, 1'b1);
      for (int k = 0; k < N; k++) send(8'(k + 8'h40), 1'b0);
      idle(3);
      check("f5_we_cnt", W'(we_cnt), W'(1));
      check("f5_row", row_data, exp_row);
      check("f5_raddr", W'(row_addr), '0);
      check("f5_frames", W'(frames_written), W'(1));

      // Three non-header bytes in IDLE
      do_reset();
      for (int k = 0; k < 3; k++) send(8'(k + 1), 1'b0);
      idle(2);
      check("f6_errcnt", W'(error_count), W'(3));
      check("f6_epulses", W'(ep_cnt), W'(3));
      check("f6_we_cnt", W'(we_cnt), '0);

      // Error counter saturation
      do_reset();
      for (int k = 0; k < 300; k++) send(8'hC3, 1'b0);
      idle(2);
      check("f7_errcnt_sat", W'(error_count), W'(255));
      check("f7_epulses", W'(ep_cnt), W'(300));
      check("f7_we_cnt", W'(we_cnt), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
